// File: rtl/axim_rd_ctrl.sv
// axim_rd_ctrl: AXI4 read master that splits a (start, address, size) request into 4KB-safe bursts streamed out on rd_t*
// Ports: clk/rst (sync, active-high); ctrl_rstart_i/ctrl_raddr_offset_i/ctrl_rxfer_size_i/ctrl_rdone_o request handshake;
//        rd_tdata_o/rd_tvalid_o/rd_tready_i/rd_tlast_o outgoing word stream with sticky rd_err_o;
//        m_axi_ar* address channel (fixed size/burst/prot/cache), m_axi_r* data channel passed straight through.
module axim_rd_ctrl #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_MAX_BURST_LEN    = 16,
  parameter int C_MAX_OUTSTANDING  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ctrl_rstart_i,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_raddr_offset_i,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_rxfer_size_i,
  output logic                          ctrl_rdone_o,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_tdata_o,
  output logic                          rd_tvalid_o,
  input  logic                          rd_tready_i,
  output logic                          rd_tlast_o,
  output logic                          rd_err_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic [7:0]                    m_axi_arlen_o,
  output logic                          m_axi_arvalid_o,
  input  logic                          m_axi_arready_i,
  output logic [2:0]                    m_axi_arsize_o,
  output logic [1:0]                    m_axi_arburst_o,
  output logic [2:0]                    m_axi_arprot_o,
  output logic [3:0]                    m_axi_arcache_o,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata_i,
  input  logic [1:0]                    m_axi_rresp_i,
  input  logic                          m_axi_rlast_i,
  input  logic                          m_axi_rvalid_i,
  output logic                          m_axi_rready_o
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int CW = C_XFER_SIZE_WIDTH - 2;
  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] addr;
  logic [CW-1:0] req_left, total, rcvd, to_4k, lim, beats;
  logic [OW-1:0] outst;
  logic run, ar_hs, r_hs;

  assign m_axi_arsize_o  = 3'b010;
  assign m_axi_arburst_o = 2'b01;
  assign m_axi_arprot_o  = 3'b000;
  assign m_axi_arcache_o = 4'b0011;

  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;

  always_comb begin
    state_nxt = state == IDLE ? (ctrl_rstart_i ? (ctrl_rxfer_size_i != '0 ? RUN : DONE) : IDLE)
              : state == RUN ? (rd_tvalid_o & rd_tready_i & rd_tlast_o ? DONE : RUN)
              : IDLE;
  end

  always_comb begin
    run             = state == RUN;
    ctrl_rdone_o    = state == DONE;
    rd_tdata_o      = m_axi_rdata_i;
    rd_tvalid_o     = m_axi_rvalid_i & run;
    m_axi_rready_o  = rd_tready_i & run;
    rd_tlast_o      = rd_tvalid_o & (rcvd == total - CW'(1));
    // words left before the next 4KB page; 1024 when sitting exactly on a page start
    to_4k           = CW'(11'd1024 - {1'b0, addr[11:2]});
    lim             = req_left < CW'(C_MAX_BURST_LEN) ? req_left : CW'(C_MAX_BURST_LEN);
    beats           = to_4k < lim ? to_4k : lim;
    m_axi_araddr_o  = addr;
    m_axi_arlen_o   = 8'(beats - CW'(1));
    m_axi_arvalid_o = run & (req_left != '0) & (outst < OW'(C_MAX_OUTSTANDING));
    ar_hs           = m_axi_arvalid_o & m_axi_arready_i;
    r_hs            = m_axi_rvalid_i & m_axi_rready_o;
  end

  // addr/req_left only move on an AR handshake, so araddr/arlen stay put while arready is low
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      req_left <= '0;
      total    <= '0;
      rcvd     <= '0;
      outst    <= '0;
      rd_err_o <= 1'b0;
    end else if (state == IDLE) begin
      if (ctrl_rstart_i) begin
        addr     <= ctrl_raddr_offset_i;
        req_left <= ctrl_rxfer_size_i[C_XFER_SIZE_WIDTH-1:2];
        total    <= ctrl_rxfer_size_i[C_XFER_SIZE_WIDTH-1:2];
        rcvd     <= '0;
        outst    <= '0;
        rd_err_o <= 1'b0;
      end
    end else begin
      if (ar_hs) begin
        addr     <= addr + AW'({beats, 2'b00});
        req_left <= req_left - beats;
      end
      if (r_hs) rcvd <= rcvd + CW'(1);
      if (r_hs && m_axi_rresp_i != 2'b00) rd_err_o <= 1'b1;
      outst <= outst + OW'(ar_hs) - OW'(r_hs & m_axi_rlast_i);
    end
  end
endmodule
